// File: rtl/mar_burst_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mar_burst_gen
//  Description : Memory address register with an N-beat burst sequencer.
//                Direct load in IDLE; in BURST the address steps by STRIDE
//                (up or down) on every beat accepted by memory.
//                Optional macro MAR_BOUND_EN turns address wrap during a
//                burst into a sticky fault instead of a silent wrap.
//  Revision    : 1.0  initial release
// ============================================================================
module mar_burst_gen #(
    parameter int AW     = 5,
    parameter int LEN_W  = 3,
    parameter int STRIDE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    in,
    output logic [AW-1:0]    out,
    input  logic             burst_start,
    input  logic [LEN_W-1:0] burst_len,
    input  logic             burst_dir,
    input  logic             burst_abort,
    input  logic             mem_ready,
    output logic             addr_valid,
    output logic             busy,
    output logic             done,
    output logic             fault
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_stride = AW'(STRIDE);

    state_t             r_state;
    state_t             w_state_nx;
    logic [LEN_W-1:0]   r_remaining;
    logic [LEN_W-1:0]   w_remaining_nx;
    logic               r_dir;
    logic               w_dir_nx;
    logic [AW-1:0]      w_out_nx;
    logic               w_done_nx;
    logic [AW-1:0]      w_step;
    logic               w_bound_hit;
    logic               w_start_ok;
    logic               w_accept;

    // Both candidate step targets; modulo-2^AW arithmetic is native width.
    assign w_step   = r_dir ? (out - c_stride) : (out + c_stride);
    assign w_accept = (r_state == BURST) && mem_ready && !burst_abort;

`ifdef MAR_BOUND_EN
    logic [AW:0] w_inc_full;
    logic        w_inc_wrap;
    logic        w_dec_wrap;
    logic        r_fault;

    // Carry out of the increment / borrow of the decrement flag a wrap.
    assign w_inc_full  = {1'b0, out} + {1'b0, c_stride};
    assign w_inc_wrap  = w_inc_full[AW];
    assign w_dec_wrap  = (out < c_stride);
    assign w_bound_hit = r_dir ? w_dec_wrap : w_inc_wrap;
    assign w_start_ok  = !r_fault;
    assign fault       = r_fault;

    // Sticky fault: set on a wrapping non-final beat, cleared by an IDLE load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if ((r_state == IDLE) && we) begin
            r_fault <= 1'b0;
        end else if (w_accept && (r_remaining != '0) && w_bound_hit) begin
            r_fault <= 1'b1;
        end
    end
`else
    assign w_bound_hit = 1'b0;
    assign w_start_ok  = 1'b1;
    assign fault       = 1'b0;
`endif

    // Outputs decoded purely from state so nothing is combinational from inputs.
    assign addr_valid = (r_state == BURST);
    assign busy       = (r_state == BURST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and datapath decisions; abort outranks a same-cycle beat.
    always_comb begin
        w_state_nx     = r_state;
        w_out_nx       = out;
        w_remaining_nx = r_remaining;
        w_dir_nx       = r_dir;
        w_done_nx      = 1'b0;
        case (r_state)
            IDLE: begin
                if (we) begin
                    w_out_nx = in;
                end
                if (burst_start && w_start_ok) begin
                    w_state_nx     = BURST;
                    w_remaining_nx = burst_len;
                    w_dir_nx       = burst_dir;
                end
            end
            BURST: begin
                if (burst_abort) begin
                    w_state_nx = IDLE;
                end else if (mem_ready) begin
                    if (r_remaining != '0) begin
                        if (w_bound_hit) begin
                            // Stop at the boundary; the fault register latches.
                            w_state_nx = IDLE;
                        end else begin
                            w_out_nx       = w_step;
                            w_remaining_nx = r_remaining - 1'b1;
                        end
                    end else begin
                        // Final beat: leave out one step past it for chaining.
                        w_out_nx   = w_step;
                        w_state_nx = IDLE;
                        w_done_nx  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Address, burst counter, direction and done-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out         <= '0;
            r_remaining <= '0;
            r_dir       <= 1'b0;
            done        <= 1'b0;
        end else begin
            out         <= w_out_nx;
            r_remaining <= w_remaining_nx;
            r_dir       <= w_dir_nx;
            done        <= w_done_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mar_burst_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mar_burst_gen
//  Description : Scoreboard bench for mar_burst_gen. The driver predicts each
//                burst's beat addresses with integer arithmetic and queues
//                them; a monitor pops one per accepted beat and compares.
//                Honours MAR_BOUND_EN when the design is built with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mar_burst_gen;

    localparam int AW     = 5;
    localparam int LEN_W  = 3;
    localparam int STRIDE = 1;
    localparam int MOD    = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             we;
    logic [AW-1:0]    in;
    logic [AW-1:0]    out;
    logic             burst_start;
    logic [LEN_W-1:0] burst_len;
    logic             burst_dir;
    logic             burst_abort;
    logic             mem_ready;
    logic             addr_valid;
    logic             busy;
    logic             done;
    logic             fault;

    int total  = 0;
    int passed = 0;
    int exp_beats[$];
    int exp_done = 0;
    int m_out    = 0;
    bit m_fault  = 1'b0;

    always #5 clk = ~clk;

    mar_burst_gen #(
        .AW     (AW),
        .LEN_W  (LEN_W),
        .STRIDE (STRIDE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .we          (we),
        .in          (in),
        .out         (out),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .burst_dir   (burst_dir),
        .burst_abort (burst_abort),
        .mem_ready   (mem_ready),
        .addr_valid  (addr_valid),
        .busy        (busy),
        .done        (done),
        .fault       (fault)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic flag_fail(input string name);
        total++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    function automatic int wrapa(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    // Monitor: every accepted beat must match the oldest predicted address.
    always @(negedge clk) begin
        if (!rst) begin
            if (addr_valid && mem_ready && !burst_abort) begin
                if (exp_beats.size() == 0) flag_fail("unexpected_beat");
                else begin
                    int e;
                    e = exp_beats.pop_front();
                    check("beat_addr", 32'(out), e);
                end
            end
            if (done) begin
                if (exp_done == 0) flag_fail("unexpected_done");
                else exp_done--;
            end
        end
    end

    task automatic do_load(input int v);
        we = 1'b1; in = AW'(v); burst_start = 1'b0;
        @(posedge clk) #1;
        we = 1'b0;
        m_out = v; m_fault = 1'b0;
        check("load_out", 32'(out), v);
        check("load_fault", 32'(fault), 0);
        check("load_busy", 32'(busy), 0);
    endtask

    task automatic run_burst(input bit with_load, input int ld, input int len, input bit dir,
                             input int abort_after, input int stall_pct, input int stall_first);
        int  full[$];
        int  a, nxt, n, fin, accepted, cyc;
        bit  f, d, ignored, abort_mode;
        check("queue_drained", 32'(exp_beats.size()), 0);
        ignored = m_fault;
        a = with_load ? ld : m_out;
        if (with_load) begin m_out = ld; m_fault = 1'b0; end
        we = with_load; in = AW'(ld); burst_start = 1'b1;
        burst_len = LEN_W'(len); burst_dir = dir; burst_abort = 1'b0;
        mem_ready = 1'($urandom);
        if (ignored) begin
            @(posedge clk) #1;
            we = 1'b0; burst_start = 1'b0;
            check("ignored_busy", 32'(busy), 0);
            check("ignored_out", 32'(out), m_out);
            check("ignored_fault", 32'(fault), 32'(m_fault));
            return;
        end
        // Reference: beat k sits at start +/- k*STRIDE; bound build stops on wrap.
        f = 1'b0; d = 1'b0; fin = 0;
        for (int k = 0; k <= len; k++) begin
            full.push_back(a);
            nxt = dir ? a - STRIDE : a + STRIDE;
            if (k < len) begin
`ifdef MAR_BOUND_EN
                if (nxt < 0 || nxt >= MOD) begin f = 1'b1; fin = a; break; end
`endif
                a = wrapa(nxt);
            end else begin
                fin = wrapa(nxt);
                d = 1'b1;
            end
        end
        n = full.size();
        abort_mode = (abort_after >= 0) && (abort_after < n);
        if (abort_mode) begin
            for (int k = 0; k < abort_after; k++) exp_beats.push_back(full[k]);
            fin = full[abort_after]; f = 1'b0; d = 1'b0;
        end else begin
            foreach (full[k]) exp_beats.push_back(full[k]);
        end
        if (d) exp_done++;
        @(posedge clk) #1;
        accepted = 0; cyc = 0;
        while (cyc < 500) begin
            cyc++;
            check("burst_busy", 32'(busy), 1);
            check("burst_valid", 32'(addr_valid), 1);
            check("burst_addr_hold", 32'(out), full[accepted]);
            we = 1'($urandom); in = AW'($urandom); burst_start = 1'($urandom);
            if (abort_mode && accepted == abort_after) begin
                mem_ready = 1'b1; burst_abort = 1'b1;
                @(posedge clk) #1;
                burst_abort = 1'b0;
                break;
            end
            mem_ready = (cyc <= stall_first) ? 1'b0 : ($urandom_range(99) >= stall_pct);
            @(posedge clk) #1;
            if (mem_ready) accepted++;
            if (!abort_mode && accepted == n) break;
        end
        if (cyc >= 500) flag_fail("burst_timeout");
        we = 1'b0; burst_start = 1'b0; mem_ready = 1'b0;
        check("end_busy", 32'(busy), 0);
        check("end_out", 32'(out), fin);
        check("end_fault", 32'(fault), 32'(f));
        check("end_done", 32'(done), 32'(d));
        m_out = fin; m_fault = f;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; in = '0; burst_start = 1'b0; burst_len = '0;
        burst_dir = 1'b0; burst_abort = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", 32'(out), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_valid", 32'(addr_valid), 0);
        check("reset_done", 32'(done), 0);
        check("reset_fault", 32'(fault), 0);
        rst = 1'b0;

        // Direct load and hold.
        do_load(12);
        @(posedge clk) #1;
        check("load_hold", 32'(out), 12);

        // Up burst, backpressure with ignored load, wrap, abort.
        do_load(3);
        run_burst(1'b0, 0, 3, 1'b0, -1, 0, 0);
        do_load(10);
        run_burst(1'b0, 0, 1, 1'b1, -1, 0, 3);
        do_load(30);
        run_burst(1'b0, 0, 2, 1'b0, -1, 0, 0);
        do_load(0);
        do_load(0);
        run_burst(1'b0, 0, 7, 1'b0, 2, 0, 0);

        // Load and start together, then downward wrap followed by a chained burst.
        run_burst(1'b1, 20, 2, 1'b1, -1, 0, 0);
        do_load(1);
        run_burst(1'b0, 0, 3, 1'b1, -1, 0, 0);
        run_burst(1'b0, 0, 1, 1'b0, -1, 0, 0);

        // Asynchronous reset in the middle of a stalled burst.
        do_load(9);
        burst_start = 1'b1; burst_len = LEN_W'(5); burst_dir = 1'b0; mem_ready = 1'b0;
        @(posedge clk) #1;
        burst_start = 1'b0;
        check("pre_reset_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", 32'(out), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_valid", 32'(addr_valid), 0);
        check("async_rst_done", 32'(done), 0);
        check("async_rst_fault", 32'(fault), 0);
        m_out = 0; m_fault = 1'b0;
        @(posedge clk) #1;
        rst = 1'b0;

        // Randomized mix of loads and bursts, back to back.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) begin
                do_load(int'($urandom_range(MOD - 1)));
            end else begin
                int len_r;
                len_r = int'($urandom_range((1 << LEN_W) - 1));
                run_burst(1'($urandom_range(3) == 0), int'($urandom_range(MOD - 1)), len_r,
                          1'($urandom), ($urandom_range(9) < 3) ? int'($urandom_range(len_r)) : -1,
                          int'($urandom_range(50)), int'($urandom_range(2)));
            end
        end

        @(posedge clk);
        @(negedge clk) #1;
        check("final_done_outstanding", 32'(exp_done), 0);
        check("final_beats_outstanding", 32'(exp_beats.size()), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
